// File: rtl/gpio_pkg.sv
// Shared types and default sizing for the GPIO-driven PWM block.
// Optional build macro GPIO_PWM_FULL_ON_EN: an all-ones duty drives the pin constantly high.
package gpio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

  localparam int PWM_CHANNELS   = 4;
  localparam int PWM_WIDTH      = 8;
  localparam int PWM_PRESCALE_W = 16;

endpackage

// File: rtl/gpio_pwm_chan.sv
// One PWM channel: shadowed duty register, compare against the shared period count, output flop.
// With GPIO_PWM_FULL_ON_EN defined, an all-ones shadow forces the output high for the whole period.
module gpio_pwm_chan
  import gpio_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pwm_q, pwm_d;
  logic             hit;

  always_comb begin
    shadow_d = load_i ? duty_i : shadow_q;
`ifdef GPIO_PWM_FULL_ON_EN
    hit = (cnt_i < shadow_q) || (&shadow_q);
`else
    hit = (cnt_i < shadow_q);
`endif
    pwm_d = run_i & hit;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/gpio_pwm.sv
// Multi-channel PWM driven from the packed GPIO output word: run FSM, prescaler, period counter.
// Build option GPIO_PWM_FULL_ON_EN is handled inside gpio_pwm_chan.
module gpio_pwm
  import gpio_pkg::*;
#(
  parameter int CHANNELS   = PWM_CHANNELS,
  parameter int WIDTH      = PWM_WIDTH,
  parameter int PRESCALE_W = PWM_PRESCALE_W
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic [PRESCALE_W-1:0]     prescale,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_tick,
  output logic                      active
);

  pwm_state_e            state_q, state_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic                  period_tick_q, period_tick_d;
  logic                  tick, wrap, load, run;

  // Leaving RUN takes priority over a coincident wrap: no pulse, no shadow reload.
  always_comb begin
    state_d       = state_q;
    psc_d         = psc_q;
    cnt_d         = cnt_q;
    period_tick_d = 1'b0;
    load          = 1'b0;
    run           = 1'b0;
    tick          = (psc_q >= prescale);
    wrap          = tick && (cnt_q == '1);
    case (state_q)
      IDLE: begin
        psc_d = '0;
        cnt_d = '0;
        if (enable) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          psc_d   = '0;
          cnt_d   = '0;
        end else begin
          run           = 1'b1;
          psc_d         = tick ? '0 : psc_q + 1'b1;
          cnt_d         = tick ? cnt_q + 1'b1 : cnt_q;
          period_tick_d = wrap;
          load          = wrap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      psc_q         <= '0;
      cnt_q         <= '0;
      period_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psc_q         <= psc_d;
      cnt_q         <= cnt_d;
      period_tick_q <= period_tick_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    gpio_pwm_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk    (clk),
      .resetn (resetn),
      .load_i (load),
      .run_i  (run),
      .duty_i (duty_in[gi*WIDTH +: WIDTH]),
      .cnt_i  (cnt_q),
      .pwm_o  (pwm_out[gi])
    );
  end

  assign period_tick = period_tick_q;
  assign active      = (state_q == RUN);

endmodule
